// File: rtl/mips_pkg.sv
// Shared MIPS core parameters, issue-request type and hazard helpers
// used by the register scoreboard.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One issue slot's request, bundled so both slots share the hazard helpers.
    typedef struct packed {
        logic      valid;
        reg_addr_t rs;
        logic      rs_used;
        reg_addr_t rt;
        logic      rt_used;
        logic      wen;
        reg_addr_t waddr;
    } iss_req_t;

    // A source stalls only if it is really read, is not r0, and has a write in flight.
    function automatic logic src_hazard(input logic used, input reg_addr_t addr,
                                        input logic busy);
        return used && (addr != '0) && busy;
    endfunction

    // True when the younger request reads the given register through a used source.
    function automatic logic reads_reg(input iss_req_t req, input reg_addr_t addr);
        return (req.rs_used && (req.rs == addr)) || (req.rt_used && (req.rt == addr));
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: up to two issues and two writebacks
// per cycle applied as one net update, clamped at zero with an underflow flag.
module sb_counter
    import mips_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc1,
    input  logic             inc2,
    input  logic             dec1,
    input  logic             dec2,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    localparam int               SUM_W   = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SUM_W-1:0] w_up;
    logic [SUM_W-1:0] w_down;
    logic [SUM_W-1:0] w_net;
    logic             w_underflow;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
        w_up        = SUM_W'(r_cnt) + SUM_W'(inc1) + SUM_W'(inc2);
        w_down      = SUM_W'(dec1) + SUM_W'(dec2);
        w_underflow = (w_down > w_up);
        w_net       = w_up - w_down;
        w_cnt_next  = r_cnt;
        if (clr || w_underflow) begin
            w_cnt_next = '0;
        end else if (w_net > CNT_MAX) begin
            w_cnt_next = '1;
        end else begin
            w_cnt_next = w_net[CNT_W-1:0];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the counters are plain flops, not a RAM, so all of them clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt = r_cnt;
    assign err = w_underflow && !clr;

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: tracks in-flight writes per register,
// grants in-order issue, counts slot-1 stalls and flags orphan writebacks.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int NREG  = mips_pkg::NREG,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  iss_valid_1,
    input  logic [REG_ADDR_W-1:0] iss_rs_1,
    input  logic [REG_ADDR_W-1:0] iss_rt_1,
    input  logic                  iss_rs_used_1,
    input  logic                  iss_rt_used_1,
    input  logic                  iss_wen_1,
    input  logic [REG_ADDR_W-1:0] iss_waddr_1,
    output logic                  iss_ready_1,
    input  logic                  iss_valid_2,
    input  logic [REG_ADDR_W-1:0] iss_rs_2,
    input  logic [REG_ADDR_W-1:0] iss_rt_2,
    input  logic                  iss_rs_used_2,
    input  logic                  iss_rt_used_2,
    input  logic                  iss_wen_2,
    input  logic [REG_ADDR_W-1:0] iss_waddr_2,
    output logic                  iss_ready_2,
    input  logic                  wb_en_1,
    input  logic [REG_ADDR_W-1:0] wb_addr_1,
    input  logic                  wb_en_2,
    input  logic [REG_ADDR_W-1:0] wb_addr_2,
    output logic [NREG-1:0]       busy_vec,
    output logic [15:0]           stall_cnt,
    output logic                  sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    iss_req_t                   w_req1;
    iss_req_t                   w_req2;
    logic [NREG-1:0][CNT_W-1:0] w_cnt;
    logic [NREG-1:0]            w_busy;
    logic [NREG-1:1]            w_err;
    logic [NREG-1:1]            w_inc1;
    logic [NREG-1:1]            w_inc2;
    logic [NREG-1:1]            w_dec1;
    logic [NREG-1:1]            w_dec2;
    logic                       w_hz1;
    logic                       w_hz2;
    logic                       w_raw;
    logic                       w_cap1;
    logic                       w_cap2;
    logic                       w_ready1;
    logic                       w_ready2;
    logic                       w_stall;
    logic [15:0]                r_stall_cnt;
    logic                       r_sb_err;
    logic                       r_err_mask;

    assign w_req1 = '{valid: iss_valid_1, rs: iss_rs_1, rs_used: iss_rs_used_1,
                      rt: iss_rt_1, rt_used: iss_rt_used_1,
                      wen: iss_wen_1, waddr: iss_waddr_1};
    assign w_req2 = '{valid: iss_valid_2, rs: iss_rs_2, rs_used: iss_rs_used_2,
                      rt: iss_rt_2, rt_used: iss_rt_used_2,
                      wen: iss_wen_2, waddr: iss_waddr_2};

    // r0 is hard-wired free: no counter instance, never busy.
    assign w_cnt[0]  = '0;
    assign w_busy[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (flush),
            .inc1  (w_inc1[r]),
            .inc2  (w_inc2[r]),
            .dec1  (w_dec1[r]),
            .dec2  (w_dec2[r]),
            .cnt   (w_cnt[r]),
            .err   (w_err[r])
        );
        assign w_busy[r] = |w_cnt[r];
    end

    // Issue grant: hazards look only at registered counters, never at this cycle's writeback.
    always_comb begin
        w_hz1 = src_hazard(w_req1.rs_used, w_req1.rs, w_busy[w_req1.rs]) ||
                src_hazard(w_req1.rt_used, w_req1.rt, w_busy[w_req1.rt]);
        w_hz2 = src_hazard(w_req2.rs_used, w_req2.rs, w_busy[w_req2.rs]) ||
                src_hazard(w_req2.rt_used, w_req2.rt, w_busy[w_req2.rt]);
        w_raw  = w_req1.wen && (w_req1.waddr != '0) && reads_reg(w_req2, w_req1.waddr);
        w_cap1 = !(w_req1.wen && (w_cnt[w_req1.waddr] == CNT_MAX));
        w_cap2 = 1'b1;
        if (w_req2.wen && (w_req2.waddr != '0)) begin
            if (w_req1.wen && (w_req1.waddr == w_req2.waddr)) begin
                w_cap2 = (w_cnt[w_req2.waddr] <= CNT_W'(1));
            end else begin
                w_cap2 = (w_cnt[w_req2.waddr] != CNT_MAX);
            end
        end
        w_ready1 = !reset && !flush && w_req1.valid && !w_hz1 && w_cap1;
        w_ready2 = w_ready1 && w_req2.valid && !w_hz2 && !w_raw && w_cap2;
    end

    always_comb begin
        w_inc1 = '0;
        w_inc2 = '0;
        w_dec1 = '0;
        w_dec2 = '0;
        for (int r = 1; r < NREG; r++) begin
            w_inc1[r] = w_ready1 && w_req1.wen && (w_req1.waddr == REG_ADDR_W'(r));
            w_inc2[r] = w_ready2 && w_req2.wen && (w_req2.waddr == REG_ADDR_W'(r));
            w_dec1[r] = wb_en_1 && (wb_addr_1 == REG_ADDR_W'(r));
            w_dec2[r] = wb_en_2 && (wb_addr_2 == REG_ADDR_W'(r));
        end
    end

    assign w_stall = iss_valid_1 && !w_ready1 && !flush;

    // After reset, writebacks of discarded instructions may still arrive; they are
    // not errors until the first new destination-writing issue re-arms checking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_sb_err    <= 1'b0;
            r_err_mask  <= 1'b1;
        end else begin
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if ((|w_err) && !r_err_mask) begin
                r_sb_err <= 1'b1;
            end
            if (|(w_inc1 | w_inc2)) begin
                r_err_mask <= 1'b0;
            end
        end
    end

    assign iss_ready_1 = w_ready1;
    assign iss_ready_2 = w_ready2;
    assign busy_vec    = w_busy;
    assign stall_cnt   = r_stall_cnt;
    assign sb_err      = r_sb_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: expected grants are queued as each step is
// driven and compared at the following negedge against a small counter model.
module tb_reg_scoreboard;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        iss_valid_1, iss_rs_used_1, iss_rt_used_1, iss_wen_1, iss_ready_1;
    logic [4:0]  iss_rs_1, iss_rt_1, iss_waddr_1;
    logic        iss_valid_2, iss_rs_used_2, iss_rt_used_2, iss_wen_2, iss_ready_2;
    logic [4:0]  iss_rs_2, iss_rt_2, iss_waddr_2;
    logic        wb_en_1, wb_en_2;
    logic [4:0]  wb_addr_1, wb_addr_2;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;
    logic        sb_err;

    typedef struct {
        string tag;
        logic  r1;
        logic  r2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt[32];
    int   m_stall;
    logic m_err;
    logic m_mask;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .iss_valid_1   (iss_valid_1),
        .iss_rs_1      (iss_rs_1),
        .iss_rt_1      (iss_rt_1),
        .iss_rs_used_1 (iss_rs_used_1),
        .iss_rt_used_1 (iss_rt_used_1),
        .iss_wen_1     (iss_wen_1),
        .iss_waddr_1   (iss_waddr_1),
        .iss_ready_1   (iss_ready_1),
        .iss_valid_2   (iss_valid_2),
        .iss_rs_2      (iss_rs_2),
        .iss_rt_2      (iss_rt_2),
        .iss_rs_used_2 (iss_rs_used_2),
        .iss_rt_used_2 (iss_rt_used_2),
        .iss_wen_2     (iss_wen_2),
        .iss_waddr_2   (iss_waddr_2),
        .iss_ready_2   (iss_ready_2),
        .wb_en_1       (wb_en_1),
        .wb_addr_1     (wb_addr_1),
        .wb_en_2       (wb_en_2),
        .wb_addr_2     (wb_addr_2),
        .busy_vec      (busy_vec),
        .stall_cnt     (stall_cnt),
        .sb_err        (sb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        flush = 0;
        {iss_valid_1, iss_rs_1, iss_rs_used_1, iss_rt_1, iss_rt_used_1, iss_wen_1, iss_waddr_1} = '0;
        {iss_valid_2, iss_rs_2, iss_rs_used_2, iss_rt_2, iss_rt_used_2, iss_wen_2, iss_waddr_2} = '0;
        {wb_en_1, wb_addr_1, wb_en_2, wb_addr_2} = '0;
    endtask

    task automatic set1(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic we, input logic [4:0] wa);
        {iss_valid_1, iss_rs_1, iss_rs_used_1, iss_rt_1, iss_rt_used_1, iss_wen_1, iss_waddr_1} =
            {v, rs, rsu, rt, rtu, we, wa};
    endtask

    task automatic set2(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic we, input logic [4:0] wa);
        {iss_valid_2, iss_rs_2, iss_rs_used_2, iss_rt_2, iss_rt_used_2, iss_wen_2, iss_waddr_2} =
            {v, rs, rsu, rt, rtu, we, wa};
    endtask

    task automatic wb(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        {wb_en_1, wb_addr_1, wb_en_2, wb_addr_2} = {e1, a1, e2, a2};
    endtask

    task automatic model_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_stall = 0;
        m_err   = 1'b0;
        m_mask  = 1'b1;
    endtask

    task automatic model_wb(input logic en, input logic [4:0] a, input logic old_mask);
        if (en && a != 0) begin
            if (m_cnt[a] == 0) begin
                if (!old_mask) m_err = 1'b1;
            end else begin
                m_cnt[a]--;
            end
        end
    endtask

    // One clock with the inputs already driven: queue expected grants, compare at negedge, advance model.
    task automatic cyc(input string tag, input logic r1, input logic r2);
        exp_t        e;
        logic [31:0] exp_busy;
        logic        old_mask;
        exp_q.push_back('{tag, r1, r2});
        @(negedge clk);
        e = exp_q.pop_front();
        exp_busy = '0;
        for (int r = 0; r < 32; r++) exp_busy[r] = (m_cnt[r] != 0);
        check({e.tag, "_rdy1"}, 32'(iss_ready_1), 32'(e.r1));
        check({e.tag, "_rdy2"}, 32'(iss_ready_2), 32'(e.r2));
        check({e.tag, "_busy"}, busy_vec, exp_busy);
        check({e.tag, "_err"}, 32'(sb_err), 32'(m_err));
        check({e.tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
        old_mask = m_mask;
        if (flush) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
        end else begin
            if (e.r1 && iss_wen_1 && iss_waddr_1 != 0) begin m_cnt[iss_waddr_1]++; m_mask = 1'b0; end
            if (e.r2 && iss_wen_2 && iss_waddr_2 != 0) begin m_cnt[iss_waddr_2]++; m_mask = 1'b0; end
            model_wb(wb_en_1, wb_addr_1, old_mask);
            model_wb(wb_en_2, wb_addr_2, old_mask);
            if (iss_valid_1 && !e.r1 && m_stall < 65535) m_stall++;
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        reset = 1'b1;
        set1(1, 0, 0, 0, 0, 1, 5);
        #3;
        check("rst_rdy1", 32'(iss_ready_1), 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_err", 32'(sb_err), 32'd0);
        #9 reset = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Read-after-write across cycles on r5.
        set1(1, 0, 0, 0, 0, 1, 5);         cyc("a_iss", 1, 0);
        set1(1, 5, 1, 0, 0, 0, 0);         cyc("a_stall1", 0, 0);
        set1(1, 5, 1, 0, 0, 0, 0);         cyc("a_stall2", 0, 0);
        set1(1, 5, 1, 0, 0, 0, 0); wb(1, 5, 0, 0); cyc("a_wb_nobypass", 0, 0);
        set1(1, 5, 1, 0, 0, 0, 0);         cyc("a_go", 1, 0);

        // Intra-pair RAW on r8.
        set1(1, 0, 0, 0, 0, 1, 8); set2(1, 0, 0, 8, 1, 0, 0); cyc("b_pair", 1, 0);
        cyc("b_busy", 0, 0);
        wb(0, 0, 1, 8);                    cyc("b_wb", 0, 0);

        // Counter capacity on r3.
        set1(1, 0, 0, 0, 0, 1, 3); set2(1, 0, 0, 0, 0, 1, 3); cyc("c_dual0", 1, 1);
        set1(1, 0, 0, 0, 0, 1, 3); set2(1, 0, 0, 0, 0, 1, 3); cyc("c_dual2", 1, 0);
        set1(1, 0, 0, 0, 0, 1, 3);         cyc("c_full", 0, 0);
        wb(1, 3, 1, 3);                    cyc("c_wb_both", 0, 0);
        set1(1, 3, 1, 0, 0, 0, 0); wb(1, 3, 0, 0); cyc("c_cnt1", 0, 0);
        set1(1, 3, 1, 0, 0, 0, 0);         cyc("c_cnt0", 1, 0);

        // Orphan writeback on r9, then r0 traffic.
        wb(0, 0, 1, 9);                    cyc("d_wb9", 0, 0);
        set1(1, 0, 0, 0, 0, 1, 0); set2(1, 9, 1, 0, 1, 0, 0); wb(1, 0, 0, 0); cyc("d_r0", 1, 1);
        cyc("d_sticky", 0, 0);

        // Flush with r1, r2, r7 pending.
        set1(1, 0, 0, 0, 0, 1, 1); set2(1, 0, 0, 0, 0, 1, 2); cyc("e_iss12", 1, 1);
        set1(1, 0, 0, 0, 0, 1, 7);         cyc("e_iss7", 1, 0);
        flush = 1'b1; set1(1, 0, 0, 0, 0, 1, 4); set2(1, 0, 0, 0, 0, 1, 6); wb(1, 1, 0, 0);
        cyc("e_flush", 0, 0);
        cyc("e_after", 0, 0);

        // Stall up to 10, then reset mid-stall.
        set1(1, 0, 0, 0, 0, 1, 5);         cyc("f_iss", 1, 0);
        repeat (10 - m_stall) begin
            set1(1, 5, 1, 0, 0, 0, 0);     cyc("f_stall", 0, 0);
        end
        set1(1, 5, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("f_stall10", 32'(stall_cnt), 32'd10);
        #1 reset = 1'b1;
        #1;
        check("f_rst_stall", 32'(stall_cnt), 32'd0);
        check("f_rst_busy", busy_vec, 32'd0);
        check("f_rst_rdy1", 32'(iss_ready_1), 32'd0);
        check("f_rst_rdy2", 32'(iss_ready_2), 32'd0);
        check("f_rst_err", 32'(sb_err), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        wb(1, 5, 0, 0);                    cyc("f_stale_wb", 0, 0);
        cyc("f_noerr", 0, 0);

        // Saturation of the stall counter.
        set1(1, 0, 0, 0, 0, 1, 5);         cyc("g_iss", 1, 0);
        set1(1, 5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        m_stall = 65534;
        set1(1, 5, 1, 0, 0, 0, 0);         cyc("g_65534", 0, 0);
        set1(1, 5, 1, 0, 0, 0, 0);         cyc("g_sat", 0, 0);
        set1(1, 5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4500; i++) @(posedge clk);
        #1;
        set1(1, 5, 1, 0, 0, 0, 0);         cyc("g_hold", 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
